// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the masked-write RAM bank.
//   clog2 / addr_width  - address sizing helpers used in parameter lists
//   RUW_*               - read-under-write policy names
//   clr_state_e         - clear sequencer states
package ram_pkg;

  localparam string RUW_WRITE_FIRST = "writeFirst";
  localparam string RUW_READ_FIRST  = "readFirst";

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    return result;
  endfunction

  // A one-word array still needs a one-bit address port.
  function automatic int unsigned addr_width(input int unsigned words);
    return (clog2(words) < 32'd1) ? 32'd1 : clog2(words);
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address once after reset so the array starts zeroed.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr_en      - high while a clear write is being issued this cycle
//   clr_addr    - address being cleared this cycle
//   init_busy   - clear in progress; the RAM ignores user commands while high
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned WORD_COUNT     = 256,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  init_busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_COUNT - 32'd1);
  localparam clr_state_e            RESET_STATE = (CLEAR_ON_RESET != 32'd0) ? CLEAR : IDLE;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next-state and address counter for the clear walk.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_d = IDLE;
          addr_d  = '0;
        end else begin
          state_d = CLEAR;
          addr_d  = addr_q + ADDR_WIDTH'(32'd1);
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // State and address registers; reset restarts the walk from address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign clr_en    = (state_q == CLEAR);
  assign init_busy = (state_q == CLEAR);
  assign clr_addr  = addr_q;

endmodule

// File: rtl/ram_1w_1r_init.sv
// ram_1w_1r_init: single-clock simple-dual-port RAM with column write mask,
// selectable read-under-write policy, 1- or 2-cycle read latency and a
// hardware clear after reset.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   init_busy                         - clear running; wr/rd commands ignored
//   wr_en, wr_mask, wr_addr, wr_data  - masked write port
//   rd_en, rd_addr                    - read command
//   rd_valid, rd_data                 - read result READ_LATENCY cycles later;
//                                       rd_data holds while rd_valid is low
module ram_1w_1r_init
  import ram_pkg::*;
#(
  parameter int unsigned WORD_COUNT       = 256,
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned MASK_WIDTH       = 4,
  parameter int unsigned READ_LATENCY     = 2,
  parameter string       READ_UNDER_WRITE = "writeFirst",
  parameter int unsigned CLEAR_ON_RESET   = 1,
  localparam int unsigned ADDR_WIDTH      = addr_width(WORD_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data
);

  localparam int unsigned         COL_WIDTH   = WORD_WIDTH / MASK_WIDTH;
  localparam bit                  WRITE_FIRST = (READ_UNDER_WRITE == RUW_WRITE_FIRST);
  localparam logic [ADDR_WIDTH:0] DEPTH       = (ADDR_WIDTH + 1)'(WORD_COUNT);

  if ((WORD_WIDTH % MASK_WIDTH) != 32'd0) begin : g_bad_mask
    $error("ram_1w_1r_init: WORD_WIDTH must be a multiple of MASK_WIDTH");
  end
  if ((READ_LATENCY != 32'd1) && (READ_LATENCY != 32'd2)) begin : g_bad_latency
    $error("ram_1w_1r_init: READ_LATENCY must be 1 or 2");
  end
  if ((READ_UNDER_WRITE != RUW_WRITE_FIRST) && (READ_UNDER_WRITE != RUW_READ_FIRST)) begin : g_bad_ruw
    $error("ram_1w_1r_init: READ_UNDER_WRITE must be writeFirst or readFirst");
  end

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_clear_seq #(
    .WORD_COUNT    (WORD_COUNT),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  logic [WORD_WIDTH-1:0] mem_q [WORD_COUNT];

  logic                  wr_in_range_s, rd_in_range_s, wr_go_s, rd_go_s;
  logic                  mem_we_s;
  logic [MASK_WIDTH-1:0] mem_col_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [WORD_WIDTH-1:0] mem_wdata_s;
  logic [WORD_WIDTH-1:0] rd_word_s;

  logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [WORD_WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;

  // Addresses at or beyond WORD_COUNT exist only for non-power-of-2 depths.
  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH);
  assign rd_in_range_s = ({1'b0, rd_addr} < DEPTH);
  assign wr_go_s       = wr_en && !init_busy && wr_in_range_s;
  assign rd_go_s       = rd_en && !init_busy;

  // Write-port source: the clear walk owns the port while busy, else the user.
  always_comb begin
    mem_we_s     = 1'b0;
    mem_col_we_s = '0;
    mem_waddr_s  = '0;
    mem_wdata_s  = '0;
    if (clr_en) begin
      mem_we_s     = 1'b1;
      mem_col_we_s = '1;
      mem_waddr_s  = clr_addr;
      mem_wdata_s  = '0;
    end else if (wr_go_s) begin
      mem_we_s     = 1'b1;
      mem_col_we_s = wr_mask;
      mem_waddr_s  = wr_addr;
      mem_wdata_s  = wr_data;
    end else begin
      mem_we_s     = 1'b0;
    end
  end

  // Storage array; deliberately not reset, the clear walk zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int unsigned c = 32'd0; c < MASK_WIDTH; c++) begin
        if (mem_col_we_s[c]) begin
          mem_q[mem_waddr_s][c*COL_WIDTH +: COL_WIDTH] <= mem_wdata_s[c*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Read word with same-address bypass; readFirst simply sees the pre-write array.
  always_comb begin
    rd_word_s = '0;
    if (rd_in_range_s) begin
      rd_word_s = mem_q[rd_addr];
      if (WRITE_FIRST && wr_en && !init_busy && (wr_addr == rd_addr)) begin
        for (int unsigned c = 32'd0; c < MASK_WIDTH; c++) begin
          if (wr_mask[c]) begin
            rd_word_s[c*COL_WIDTH +: COL_WIDTH] = wr_data[c*COL_WIDTH +: COL_WIDTH];
          end
        end
      end else begin
        rd_word_s = mem_q[rd_addr];
      end
    end else begin
      rd_word_s = '0;
    end
  end

  // Read pipeline next values; data stages only load when their valid is set.
  always_comb begin
    s1_valid_d = rd_go_s;
    s1_data_d  = rd_go_s ? rd_word_s : s1_data_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
  end

  // Read pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign rd_valid = (READ_LATENCY == 32'd1) ? s1_valid_q : s2_valid_q;
  assign rd_data  = (READ_LATENCY == 32'd1) ? s1_data_q  : s2_data_q;

endmodule

// File: doc/ram_1w_1r_init.md
Name: ram_1w_1r_init

Overview:
Single-clock simple-dual-port RAM: one write port with per-column mask, one read port.
- Generalises the existing masked-write RAMs with four additions:
  - configurable read latency (1 or 2);
  - selectable read-under-write policy, resolved in logic;
  - a read-valid pipeline tag;
  - a hardware clear sequencer that zeroes the whole array after reset.
- Used as the neuron-state / weight cache bank in the SNN core. A clean array after reset is mandatory, so no init file is needed.

Parameters:
- WORD_COUNT, 256: number of words; need not be a power of 2.
- WORD_WIDTH, 32: data width in bits.
- MASK_WIDTH, 4: write-mask columns. WORD_WIDTH mod MASK_WIDTH != 0 is an elaboration error.
- READ_LATENCY, 2: cycles from rd_en to rd_valid. Legal values 1 or 2; any other value is an elaboration error.
- READ_UNDER_WRITE, "writeFirst": same-cycle same-address policy, "writeFirst" or "readFirst".
- CLEAR_ON_RESET, 1: 1 = zero the array after reset; 0 = no clear.
- Derived: ADDR_WIDTH = max(1, clog2(WORD_COUNT)); COL_WIDTH = WORD_WIDTH/MASK_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active high
- init_busy  out  1  clear sequence in progress; all port commands ignored while high
- wr_en  in  1  write strobe
- wr_mask  in  MASK_WIDTH  per-column write enable
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  WORD_WIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_WIDTH  read address
- rd_valid  out  1  rd_data carries the result of a read issued READ_LATENCY cycles earlier
- rd_data  out  WORD_WIDTH  read data

Behaviour:

Reset values:
- While reset is high: rd_valid=0, rd_data=0, read pipeline valid bits cleared.
- init_busy = CLEAR_ON_RESET on the first cycle after reset deasserts.
- Array contents are not reset directly; only the clear sequence zeroes them.

Clear FSM, states IDLE and CLEAR:
- reset forces CLEAR with clr_addr=0 when CLEAR_ON_RESET=1, otherwise IDLE.
- In CLEAR: each cycle write 0 to all columns of clr_addr, then clr_addr++.
- After writing WORD_COUNT-1, go to IDLE. init_busy is therefore high for exactly WORD_COUNT cycles after reset release.
- reset asserted mid-clear restarts the sequence at address 0.
- While init_busy=1: wr_en and rd_en are ignored (no write, no rd_valid). rd_en is not queued.

Write:
- If wr_en=1 and init_busy=0, column i of word wr_addr takes wr_data[i*COL_WIDTH +: COL_WIDTH] for every i with wr_mask[i]=1.
- The write is visible to reads issued in the next cycle or later.
- wr_mask=0 is a no-op.

Read:
- rd_en=1 at cycle T (init_busy=0) gives rd_valid=1 and rd_data = word at cycle T+READ_LATENCY.
- READ_LATENCY=2: a registered output stage is inserted.
- Back-to-back reads give one result per cycle; there is no backpressure.
- rd_data holds its last value when rd_valid=0.

Read-under-write (rd_en and wr_en in the same cycle, rd_addr==wr_addr):
- "writeFirst": columns with mask=1 return the new wr_data; unmasked columns return the old value.
- "readFirst": the whole old word is returned.
- A write at T+1 never alters the result of a read issued at T.

Out-of-range addresses (addr >= WORD_COUNT, non-power-of-2 depth):
- Write is dropped.
- Read returns 0 with rd_valid still asserted.

Simultaneous events:
- A read and a write to different addresses in the same cycle are independent.
- reset overrides every other input.

Decomposition:
- Shared package ram_pkg:
  - clog2 function;
  - RUW_WRITE_FIRST / RUW_READ_FIRST constants;
  - clear FSM state enum (IDLE, CLEAR).
- One sub-module, ram_clear_seq: the FSM plus address counter, outputting clr_en, clr_addr, init_busy.
- Storage array, write merge, bypass mux and read pipeline stay in the top module.

Test Plan:
1. WORD_COUNT=256, CLEAR_ON_RESET=1, reset for 3 cycles → init_busy high exactly 256 cycles. A wr_en/rd_en issued during busy is ignored. After busy, reads of addresses 0, 128 and 255 return 0x00000000.
2. Write 0xDEADBEEF to 0x10 with mask 0xF, then 0x000000AA with mask 0x1 → a read of 0x10 returns 0xDEADBEAA, rd_valid exactly 2 cycles after rd_en (1 cycle with READ_LATENCY=1).
3. Addr 0x20 holds 0x11223344; same cycle write 0xAABBCCDD with mask 0x3 and read 0x20 → "writeFirst" returns 0x1122CCDD, "readFirst" returns 0x11223344. The next read returns 0x1122CCDD in both modes.
4. Reads of 0x00..0x07 on 8 consecutive cycles → 8 consecutive rd_valid pulses, in order, with correct data. rd_data holds the last value afterwards with rd_valid=0.
5. reset asserted at cycle 100 of the clear → sequence restarts, init_busy high another 256 cycles. A word written to 200 before the second reset reads 0 afterwards.
6. WORD_COUNT=200: write 0x55 to address 250 and read 250 → read returns 0 with rd_valid=1, and address 250 mod 200 (=50) is unchanged.
